// File: rtl/nibble_serial_adder_pkg.sv
// ============================================================================
// Module   : nibble_add_pkg
// Purpose  : Shared definitions for the nibble-serial adder: FSM state
//            encoding and the width of the shared adder slice.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_add_pkg;

  // Width of the ripple-carry slice reused on every nibble
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage : nibble_add_pkg

`default_nettype wire

// File: rtl/nibble_serial_adder_ffulladd.sv
// ============================================================================
// Module   : ffulladd
// Purpose  : Combinational W-bit ripple-carry adder, used as the single
//            shared slice of the nibble-serial adder.
// Ports    : a_i, b_i  - W-bit addends
//            cin_i     - carry in
//            sum_o     - W-bit sum
//            cout_o    - carry out of the MSB
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ffulladd
  import nibble_add_pkg::*;
#(
  parameter int W = NIBBLE_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] carry_w;

  assign carry_w[0] = cin_i;

  generate
    for (genvar k = 0; k < W; k++) begin : g_bit
      assign sum_o[k]       = a_i[k] ^ b_i[k] ^ carry_w[k];
      assign carry_w[k + 1] = (a_i[k] & b_i[k]) | (carry_w[k] & (a_i[k] ^ b_i[k]));
    end
  endgenerate

  assign cout_o = carry_w[W];

endmodule : ffulladd

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module   : nibble_serial_adder
// Purpose  : Adds two WIDTH-bit operands one nibble per clock, LSB nibble
//            first, through a single shared 4-bit ripple-carry slice. The
//            inter-nibble carry lives in a register.
// Ports    : clk, rst              - clock, async active-high reset
//            in_valid / in_ready   - operand handshake (ready only in IDLE)
//            a, b, cin             - operands, sampled on accept
//            sub                   - subtract select (NIBBLE_ADD_SUB_EN only)
//            out_valid / out_ready - result handshake (valid only in DONE)
//            sum, cout             - registered result and final carry
//            busy                  - high in RUN or DONE
// Config   : define NIBBLE_ADD_SUB_EN to add the `sub` port (a - b mode).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
      $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_e               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     sum_q;
  logic                 carry_q;
  logic                 cout_q;
  logic [IDX_W-1:0]     idx_q;

  // Values loaded into the operand/carry registers on accept
  logic [WIDTH-1:0]     b_d;
  logic                 carry_d;

`ifdef NIBBLE_ADD_SUB_EN
  // a - b is computed as a + ~b + 1; cin is irrelevant in that mode
  assign b_d     = sub ? ~b : b;
  assign carry_d = sub ? 1'b1 : cin;
`else
  assign b_d     = b;
  assign carry_d = cin;
`endif

  // Operand nibble select for the current index
  logic [NIBBLE_W-1:0]  a_nib;
  logic [NIBBLE_W-1:0]  b_nib;
  logic [NIBBLE_W-1:0]  slice_sum;
  logic                 slice_cout;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == n[IDX_W-1:0]) begin
        a_nib = a_q[n*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[n*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  ffulladd #(
    .W (NIBBLE_W)
  ) u_slice (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= RUN;
          end
        end

        RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == n[IDX_W-1:0]) begin
              sum_q[n*NIBBLE_W +: NIBBLE_W] <= slice_sum;
            end
          end
          carry_q <= slice_cout;
          if (idx_q == LAST_IDX) begin
            cout_q  <= slice_cout;
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDX_ONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake flags depend only on the state register
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule : nibble_serial_adder

`default_nettype wire
